// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared types for the immediate / branch-target unit.
//   fmt_e        : immediate format code reported on out_fmt
//   buf_state_e  : occupancy of the 2-entry output buffer
//   OP_*/...     : RV base opcodes recognised by the decoder
//   dec_entry_t  : one decoded instruction as stored in the buffer. The
//                  imm/target fields are MAX_XLEN wide. A unit built with a
//                  smaller XLEN zero-fills the upper bits.
// ---------------------------------------------------------------------------
package imm_pkg;

    localparam int MAX_XLEN = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef struct packed {
        logic [MAX_XLEN-1:0] imm;
        logic [MAX_XLEN-1:0] target;
        fmt_e                fmt;
        logic                illegal;
    } dec_entry_t;

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
// Purely combinational immediate and target decoder.
//   instr : 32-bit instruction word
//   pc    : XLEN-bit PC of instr
//   entry : decoded immediate, target, format and illegal flag
// All arithmetic is done at exactly XLEN bits. Sign extension is a signed
// cast of the assembled field up to XLEN. The target addition wraps
// modulo 2^XLEN.
// ---------------------------------------------------------------------------
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output dec_entry_t      entry
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] target;
    logic            pc_relative;
    fmt_e            fmt;
    logic            illegal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // RV64 shift amounts carry one extra bit.
    assign shamt = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);

    always_comb begin
        imm         = '0;
        fmt         = FMT_NONE;
        illegal     = 1'b0;
        pc_relative = 1'b0;
        case (opcode)
            OP_IMM, LOAD, JALR, SYSTEM: begin
                fmt = FMT_I;
                if (opcode == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101)) begin
                    imm = shamt;
                end else begin
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            BRANCH: begin
                fmt         = FMT_B;
                imm         = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                             instr[11:8], 1'b0}));
                pc_relative = 1'b1;
            end
            LUI: begin
                fmt = FMT_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            AUIPC: begin
                fmt         = FMT_U;
                imm         = XLEN'($signed({instr[31:12], 12'b0}));
                pc_relative = 1'b1;
            end
            JAL: begin
                fmt         = FMT_J;
                imm         = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                             instr[30:21], 1'b0}));
                pc_relative = 1'b1;
            end
            OP: begin
                fmt = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign target = pc + (pc_relative ? imm : XLEN'(4));

    always_comb begin
        entry         = '0;
        entry.imm     = MAX_XLEN'(imm);
        entry.target  = MAX_XLEN'(target);
        entry.fmt     = fmt;
        entry.illegal = illegal;
    end

endmodule

// File: rtl/imm_target_unit.sv
// ---------------------------------------------------------------------------
// imm_target_unit
// Decode-stage immediate / branch-target unit behind a 2-entry skid buffer.
//   clk, reset        : clock, synchronous active-high reset
//   flush             : drop every buffered entry and any push this cycle
//   in_valid/in_ready : upstream handshake. in_ready comes from a register.
//   in_instr, in_pc   : instruction and its PC
//   out_valid/out_ready : downstream handshake
//   out_imm, out_target, out_fmt, out_illegal : head-of-buffer decode result
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid must not depend on ready. Outputs of a valid entry hold
// stable until it is accepted.
//
// Instructions are decoded on entry and stored decoded. Outputs are read
// directly from the head slot, so they are register outputs.
// ---------------------------------------------------------------------------
module imm_target_unit
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output fmt_e            out_fmt,
    output logic            out_illegal
);

    dec_entry_t decoded;
    dec_entry_t mem [2];
    dec_entry_t head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       ready_q;
    logic       push;
    logic       pop;
    buf_state_e state;
    buf_state_e state_next;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .entry (decoded)
    );

    assign push = in_valid && ready_q;
    assign pop  = out_valid && out_ready;

    // Occupancy state. A push in FULL cannot happen because ready_q is low.
    always_comb begin
        state_next = state;
        case (state)
            BUF_EMPTY: if (push) state_next = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop) state_next = BUF_FULL;
                else if (pop && !push) state_next = BUF_EMPTY;
            end
            BUF_FULL: if (pop) state_next = BUF_ONE;
            default: state_next = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BUF_EMPTY;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            ready_q <= 1'b1;
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else if (flush) begin
            state   <= BUF_EMPTY;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= decoded;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            state   <= state_next;
            // Ready for next cycle is known from the next occupancy.
            ready_q <= (state_next != BUF_FULL);
        end
    end

    assign head        = mem[rd_ptr];
    assign in_ready    = ready_q;
    assign out_valid   = (state != BUF_EMPTY);
    assign out_imm     = head.imm[XLEN-1:0];
    assign out_target  = head.target[XLEN-1:0];
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;

    // Upper halves exist only for the widest configuration.
    if (XLEN < MAX_XLEN) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{head.imm[MAX_XLEN-1:XLEN], head.target[MAX_XLEN-1:XLEN]};
    end

endmodule

// File: tb/tb_imm_target_unit.sv
// ---------------------------------------------------------------------------
// tb_imm_target_unit
// Two instances (XLEN=32 and XLEN=64) share one stimulus stream. A queue
// model of the buffer plus an arithmetic decode reference predicts every
// cycle's handshake and head entry.
// ---------------------------------------------------------------------------
module tb_imm_target_unit;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc32;
  logic [63:0] in_pc64;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_target32;
  fmt_e        out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64, out_target64;
  fmt_e        out_fmt64;

  int tests = 0;
  int fails = 0;

  logic [131:0] exp32_q[$];
  logic [131:0] exp64_q[$];
  logic         model_ready;

  always #5 clk = ~clk;

  imm_target_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc32),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_target(out_target32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32)
  );

  imm_target_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_target(out_target64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] m;
    m = (64'd1 << bits) - 64'd1;
    v = v & m;
    if (v[bits-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [131:0] ref_decode(input logic [31:0] ins, input logic [63:0] pc,
                                              input int xlen);
    logic [63:0] u, imm, tgt, mask;
    logic [2:0]  f;
    logic        ill, rel;
    u = {32'b0, ins};
    imm = 64'd0; f = 3'd0; ill = 1'b0; rel = 1'b0;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin
        f = 3'd2;
        imm = sx(u >> 20, 12);
        if (ins[6:0] == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5))
          imm = (u >> 20) & ((xlen == 64) ? 64'd63 : 64'd31);
      end
      7'h23: begin f = 3'd3; imm = sx(((u >> 25) << 5) | ((u >> 7) & 64'd31), 12); end
      7'h63: begin
        f = 3'd4; rel = 1'b1;
        imm = sx((((u >> 31) & 64'd1) << 12) | (((u >> 7) & 64'd1) << 11) |
                 (((u >> 25) & 64'd63) << 5) | (((u >> 8) & 64'd15) << 1), 13);
      end
      7'h37: begin f = 3'd5; imm = sx(u & 64'hFFFF_F000, 32); end
      7'h17: begin f = 3'd5; imm = sx(u & 64'hFFFF_F000, 32); rel = 1'b1; end
      7'h6F: begin
        f = 3'd6; rel = 1'b1;
        imm = sx((((u >> 31) & 64'd1) << 20) | (((u >> 12) & 64'd255) << 12) |
                 (((u >> 20) & 64'd1) << 11) | (((u >> 21) & 64'd1023) << 1), 21);
      end
      7'h33: f = 3'd1;
      default: ill = 1'b1;
    endcase
    imm = imm & mask;
    tgt = (pc + (rel ? imm : 64'd4)) & mask;
    return {ill, f, tgt, imm};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [131:0] e;
    chk("in_ready32", 64'(in_ready32), 64'(model_ready));
    chk("in_ready64", 64'(in_ready64), 64'(model_ready));
    chk("out_valid32", 64'(out_valid32), 64'(exp32_q.size() > 0));
    chk("out_valid64", 64'(out_valid64), 64'(exp64_q.size() > 0));
    if (exp32_q.size() > 0) begin
      e = exp32_q[0];
      chk("imm32", 64'(out_imm32), e[63:0]);
      chk("target32", 64'(out_target32), e[127:64]);
      chk("fmt32", 64'(out_fmt32), 64'(e[130:128]));
      chk("illegal32", 64'(out_illegal32), 64'(e[131]));
    end
    if (exp64_q.size() > 0) begin
      e = exp64_q[0];
      chk("imm64", out_imm64, e[63:0]);
      chk("target64", out_target64, e[127:64]);
      chk("fmt64", 64'(out_fmt64), 64'(e[130:128]));
      chk("illegal64", 64'(out_illegal64), 64'(e[131]));
    end
  endtask

  // One clock: check current outputs, drive inputs, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic ordy, input logic fl, input logic rst);
    logic do_push, do_pop;
    check_all();
    in_valid = v; in_instr = ins; in_pc32 = pc[31:0]; in_pc64 = pc;
    out_ready = ordy; flush = fl; reset = rst;
    if (rst || fl) begin
      exp32_q.delete();
      exp64_q.delete();
      model_ready = 1'b1;
    end else begin
      do_pop  = (exp32_q.size() > 0) && ordy;
      do_push = v && model_ready;
      if (do_pop) begin
        void'(exp32_q.pop_front());
        void'(exp64_q.pop_front());
      end
      if (do_push) begin
        exp32_q.push_back(ref_decode(ins, {32'b0, pc[31:0]}, 32));
        exp64_q.push_back(ref_decode(ins, pc, 64));
      end
      model_ready = (exp32_q.size() < 2);
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    logic [131:0] r;
    logic [31:0]  ins;
    logic [63:0]  pc;
    int           k;

    // Pin the reference model with hand-derived values.
    r = ref_decode(32'hFE000EE3, 64'h100, 32);
    chk("model_beq_imm", r[63:0], 64'hFFFF_FFFC);
    chk("model_beq_tgt", r[127:64], 64'h0000_00FC);
    r = ref_decode(32'h001000EF, 64'h1000, 32);
    chk("model_jal_tgt", r[127:64], 64'h1800);
    r = ref_decode(32'h01F09093, 64'h0, 64);
    chk("model_slli64", r[63:0], 64'd31);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc32 = 32'h0; in_pc64 = 64'h0;
    model_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_in_ready", 64'(in_ready32), 64'd1);
    chk("rst_imm", 64'(out_imm32), 64'd0);
    chk("rst_target", 64'(out_target32), 64'd0);
    chk("rst_fmt", 64'(out_fmt32), 64'(FMT_NONE));
    chk("rst_illegal", 64'(out_illegal32), 64'd0);
    chk("rst_imm64", out_imm64, 64'd0);

    // Directed decodes, one per cycle with out_ready high.
    step(1, 32'hFE000EE3, 64'h100, 1, 0, 0);
    chk("beq_valid", 64'(out_valid32), 64'd1);
    chk("beq_imm", 64'(out_imm32), 64'hFFFF_FFFC);
    chk("beq_target", 64'(out_target32), 64'h0000_00FC);
    chk("beq_fmt", 64'(out_fmt32), 64'(FMT_B));
    step(1, 32'h001000EF, 64'h1000, 1, 0, 0);
    chk("jal_imm", 64'(out_imm32), 64'h800);
    chk("jal_target", 64'(out_target32), 64'h1800);
    chk("jal_fmt", 64'(out_fmt32), 64'(FMT_J));
    step(1, 32'hFE21AC23, 64'h0, 1, 0, 0);
    chk("sw_imm", 64'(out_imm32), 64'hFFFF_FFF8);
    chk("sw_fmt", 64'(out_fmt32), 64'(FMT_S));
    step(1, 32'h123452B7, 64'h200, 1, 0, 0);
    chk("lui_imm", 64'(out_imm32), 64'h1234_5000);
    chk("lui_target", 64'(out_target32), 64'h204);
    step(1, 32'h01F09093, 64'h40, 1, 0, 0);
    chk("slli32_imm", 64'(out_imm32), 64'd31);
    chk("slli64_imm", out_imm64, 64'd31);
    step(1, 32'h0000007F, 64'h300, 1, 0, 0);
    chk("illegal_flag", 64'(out_illegal32), 64'd1);
    chk("illegal_imm", 64'(out_imm32), 64'd0);
    chk("illegal_fmt", 64'(out_fmt32), 64'(FMT_NONE));
    step(1, 32'h00000013, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0);
    chk("wrap_target64", out_target64, 64'd0);
    chk("wrap_target32", 64'(out_target32), 64'd0);
    step(0, 32'h0, 64'h0, 1, 0, 0);

    // Stall: three back-to-back valids with out_ready low.
    step(1, 32'h00100093, 64'h500, 0, 0, 0);
    step(1, 32'h00200113, 64'h504, 0, 0, 0);
    chk("stall_ready_low", 64'(in_ready32), 64'd0);
    step(1, 32'h00300193, 64'h508, 0, 0, 0);
    chk("stall_hold_imm", 64'(out_imm32), 64'd1);
    step(1, 32'h00300193, 64'h508, 0, 0, 0);
    step(1, 32'h00300193, 64'h508, 1, 0, 0);
    chk("drain_second", 64'(out_imm32), 64'd2);
    step(1, 32'h00300193, 64'h508, 1, 0, 0);
    step(0, 32'h0, 64'h0, 1, 0, 0);
    step(0, 32'h0, 64'h0, 1, 0, 0);

    // Flush with a full buffer and a coincident valid.
    step(1, 32'h00A00513, 64'h600, 0, 0, 0);
    step(1, 32'h00B00593, 64'h604, 0, 0, 0);
    step(1, 32'h00C00613, 64'h608, 0, 1, 0);
    chk("flush_valid", 64'(out_valid32), 64'd0);
    chk("flush_ready", 64'(in_ready32), 64'd1);
    step(0, 32'h0, 64'h0, 1, 0, 0);
    // Flush in ONE where the push would otherwise be accepted.
    step(1, 32'h00D00693, 64'h700, 0, 0, 0);
    step(1, 32'h00E00713, 64'h704, 0, 1, 0);
    chk("flush1_valid", 64'(out_valid64), 64'd0);
    step(0, 32'h0, 64'h0, 1, 0, 0);
    // Reset with a full buffer and a coincident valid.
    step(1, 32'h00F00793, 64'h800, 0, 0, 0);
    step(1, 32'h01000813, 64'h804, 0, 0, 0);
    step(1, 32'h01100893, 64'h808, 0, 0, 1);
    chk("reset_valid", 64'(out_valid32), 64'd0);
    chk("reset_ready", 64'(in_ready32), 64'd1);
    step(0, 32'h0, 64'h0, 1, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 10);
      ins[31:7] = 25'($urandom);
      ins[6:0]  = (k == 10) ? 7'($urandom) : ops[k];
      case ($urandom_range(0, 3))
        0: pc = {32'hFFFF_FFFF, 32'hFFFF_FF00 | 32'($urandom_range(0, 255))};
        1: pc = {32'h0, 32'hFFFF_FF00 | 32'($urandom_range(0, 255))};
        default: pc = {$urandom, $urandom};
      endcase
      step(1'($urandom_range(0, 9) < 7), ins, pc, 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 199) < 1));
    end
    for (int i = 0; i < 4; i++) step(0, 32'h0, 64'h0, 1, 0, 0);
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
